branch_target_buffer: RTL

- Fetch-stage predictor: direct-mapped branch target buffer (BTB) with a 1-bit branch history per entry.
- Looked up combinationally with PCF in IF. Produces BranchFlagsF[1:0] and the predicted next PC.
- BranchFlagsF is piped through the IF/ID and ID/EX registers to become BranchFlagsE at the branch decision stage.
- Updated synchronously from EX once the branch outcome is resolved. Keeps branch and misprediction counters for evaluating the predictor.

---
 rtl/branch_target_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target_buffer
//  Purpose  : Direct-mapped branch target buffer with 1-bit history per entry.
//             Combinational lookup in IF, synchronous update from EX, and
//             saturating branch / misprediction statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
  parameter int ENTRY_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          PCF,
  output logic [1:0]           BranchFlagsF,
  output logic [31:0]          PredictedPCF,
  input  logic                 UpdateEnE,
  input  logic [31:0]          PCE,
  input  logic [31:0]          BrTargetE,
  input  logic                 ActualTakenE,
  input  logic [1:0]           BranchFlagsE,
  output logic [CNT_WIDTH-1:0] BranchCnt,
  output logic [CNT_WIDTH-1:0] MispredCnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 30 - ENTRY_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Address split: word-aligned index, remaining upper bits form the tag.
  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]      tag_f, tag_e;

  assign idx_f = PCF[ENTRY_BITS+1:2];
  assign tag_f = PCF[31:ENTRY_BITS+2];
  assign idx_e = PCE[ENTRY_BITS+1:2];
  assign tag_e = PCE[31:ENTRY_BITS+2];

  // Byte offset and the carried hit flag are intentionally not used; the
  // hit is re-derived from the tag array at update time.
  logic unused_bits;
  assign unused_bits = ^{PCF[1:0], PCE[1:0], BranchFlagsE[1]};

  // Entry storage: valid/hist are reset, tag/target are masked by valid.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] hist_q, hist_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  logic hit_f, pred_taken_f, hit_e, alloc_we;

  // Fetch-side lookup; reads pre-update contents, no write-through bypass.
  always_comb begin
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken_f = hit_f && hist_q[idx_f];
    BranchFlagsF = {hit_f, pred_taken_f};
    PredictedPCF = pred_taken_f ? target_q[idx_f] : (PCF + 32'd4);
  end

  // Next-state for valid/history bits and the statistics counters.
  always_comb begin
    hit_e         = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    alloc_we      = UpdateEnE && ActualTakenE && !rst;
    valid_d       = valid_q;
    hist_d        = hist_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (UpdateEnE) begin
      if (ActualTakenE) begin
        // Taken: refresh a matching entry or allocate over any alias.
        valid_d[idx_e] = 1'b1;
        hist_d[idx_e]  = 1'b1;
      end else if (hit_e) begin
        // Not taken: only a matching entry learns; misses never allocate.
        hist_d[idx_e] = 1'b0;
      end
      if (branch_cnt_q != {CNT_WIDTH{1'b1}}) begin
        branch_cnt_d = branch_cnt_q + CNT_ONE;
      end
      if ((BranchFlagsE[0] != ActualTakenE) &&
          (mispred_cnt_q != {CNT_WIDTH{1'b1}})) begin
        mispred_cnt_d = mispred_cnt_q + CNT_ONE;
      end
    end
  end

  // Resettable state: valid/hist bits and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      hist_q        <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      hist_q        <= hist_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag/target arrays: written on every taken update (refresh or allocate).
  always_ff @(posedge clk) begin
    if (alloc_we) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= BrTargetE;
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule
`default_nettype wire
